// File: rtl/fismos_axil_master_if.sv
// AXI4-Lite channel bundle for the fismos_axil_master initiator.
// Member names follow the M_AXI_* port naming of the bridge.
interface fismos_axil_master_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  logic                        AWVALID;
  logic                        AWREADY;
  logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                  AWPROT;
  logic                        WVALID;
  logic                        WREADY;
  logic [AXI_DATA_WIDTH-1:0]   WDATA;
  logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                        BVALID;
  logic                        BREADY;
  logic [1:0]                  BRESP;
  logic                        ARVALID;
  logic                        ARREADY;
  logic [AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                  ARPROT;
  logic                        RVALID;
  logic                        RREADY;
  logic [AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                  RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/fismos_axil_master.sv
// PicoRV32 native memory port -> single-beat AXI4-Lite master for one address window.
// Optional handshake timeout: define FISMOS_AXIL_MASTER_TIMEOUT_EN.
module fismos_axil_master #(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter logic [31:0] WINDOW_BYTES   = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_valid,
  input  logic                        mem_instr,
  input  logic [31:0]                 mem_addr,
  input  logic [31:0]                 mem_wdata,
  input  logic [3:0]                  mem_wstrb,
  output logic                        mem_ready,
  output logic [31:0]                 mem_rdata,
  fismos_axil_master_if.master        M_AXI,
  output logic                        bus_error
);

  generate
    if (AXI_DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("fismos_axil_master: AXI_DATA_WIDTH must be 32 and TIMEOUT_CYCLES >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_awvalid, w_awvalid_nxt;
  logic                      r_wvalid, w_wvalid_nxt;
  logic                      r_bready, w_bready_nxt;
  logic                      r_arvalid, w_arvalid_nxt;
  logic                      r_rready, w_rready_nxt;
  logic                      r_err, w_err_nxt;
  logic                      r_instr, w_instr_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]               r_wdata, w_wdata_nxt;
  logic [3:0]                r_wstrb, w_wstrb_nxt;
  logic [31:0]               r_rdata, w_rdata_nxt;

  logic [31:0] w_off;
  logic        w_hit;
  logic        w_aw_done, w_w_done;

  // Window test done on the offset so BASE+WINDOW may wrap past 2^32 safely.
  assign w_off     = mem_addr - BASE_ADDR;
  assign w_hit     = (mem_addr >= BASE_ADDR) && (w_off < WINDOW_BYTES);
  assign w_aw_done = !r_awvalid || M_AXI.AWREADY;
  assign w_w_done  = !r_wvalid  || M_AXI.WREADY;

`ifdef FISMOS_AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_tmo_cnt;
  logic          w_busy;

  assign w_busy = (r_state == WRITE) || (r_state == WRESP) ||
                  (r_state == READ)  || (r_state == RDATA);

  // Restarts on every state change, so each handshake phase gets its own budget.
  always_ff @(posedge clk) begin
    if (reset)                         r_tmo_cnt <= '0;
    else if (w_state_nxt != r_state)   r_tmo_cnt <= '0;
    else if (w_busy)                   r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_bready_nxt  = r_bready;
    w_arvalid_nxt = r_arvalid;
    w_rready_nxt  = r_rready;
    w_err_nxt     = r_err;
    w_instr_nxt   = r_instr;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_wstrb_nxt   = r_wstrb;
    w_rdata_nxt   = r_rdata;
    unique case (r_state)
      IDLE: begin
        if (mem_valid && w_hit && !mem_ready) begin
          w_addr_nxt  = AXI_ADDR_WIDTH'({w_off[31:2], 2'b00});
          w_wdata_nxt = mem_wdata;
          w_wstrb_nxt = mem_wstrb;
          w_instr_nxt = mem_instr;
          if (mem_wstrb != 4'b0000) begin
            w_state_nxt   = WRITE;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = READ;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        w_awvalid_nxt = r_awvalid && !M_AXI.AWREADY;
        w_wvalid_nxt  = r_wvalid  && !M_AXI.WREADY;
        if (w_aw_done && w_w_done) begin
          w_state_nxt  = WRESP;
          w_bready_nxt = 1'b1;
        end
      end
      WRESP: begin
        if (M_AXI.BVALID) begin
          w_bready_nxt = 1'b0;
          w_err_nxt    = r_err || (M_AXI.BRESP != 2'b00);
          w_state_nxt  = DONE;
        end
      end
      READ: begin
        if (M_AXI.ARREADY) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = RDATA;
        end
      end
      RDATA: begin
        if (M_AXI.RVALID) begin
          w_rdata_nxt  = M_AXI.RDATA;
          w_rready_nxt = 1'b0;
          w_err_nxt    = r_err || (M_AXI.RRESP != 2'b00);
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        w_rdata_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef FISMOS_AXIL_MASTER_TIMEOUT_EN
    // A phase that made no progress by its last allowed cycle is abandoned.
    if (w_busy && (w_state_nxt == r_state) && (r_tmo_cnt == TMO_LAST)) begin
      w_awvalid_nxt = 1'b0;
      w_wvalid_nxt  = 1'b0;
      w_bready_nxt  = 1'b0;
      w_arvalid_nxt = 1'b0;
      w_rready_nxt  = 1'b0;
      w_err_nxt     = 1'b1;
      w_rdata_nxt   = 32'hDEAD_BEEF;
      w_state_nxt   = DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_err     <= 1'b0;
      r_instr   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      r_arvalid <= w_arvalid_nxt;
      r_rready  <= w_rready_nxt;
      r_err     <= w_err_nxt;
      r_instr   <= w_instr_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_rdata   <= w_rdata_nxt;
    end
  end

  assign mem_ready     = (r_state == DONE);
  assign mem_rdata     = r_rdata;
  assign bus_error     = r_err;

  assign M_AXI.AWVALID = r_awvalid;
  assign M_AXI.AWADDR  = r_addr;
  assign M_AXI.AWPROT  = 3'b000;
  assign M_AXI.WVALID  = r_wvalid;
  assign M_AXI.WDATA   = r_wdata;
  assign M_AXI.WSTRB   = r_wstrb;
  assign M_AXI.BREADY  = r_bready;
  assign M_AXI.ARVALID = r_arvalid;
  assign M_AXI.ARADDR  = r_addr;
  assign M_AXI.ARPROT  = {r_instr, 2'b00};
  assign M_AXI.RREADY  = r_rready;

endmodule

// File: tb/tb_fismos_axil_master.sv
// Self-checking bench for fismos_axil_master: randomized requests against a
// delay-programmable AXI-Lite slave and a spec-level expectation model.
module tb_fismos_axil_master;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] WIN  = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, bus_error;
  logic [31:0] mem_rdata;

  fismos_axil_master_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) axi ();

  fismos_axil_master #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .BASE_ADDR(BASE),
    .WINDOW_BYTES(WIN), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .M_AXI(axi), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // slave knobs and monitor results
  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  b_resp = 2'b00, r_resp = 2'b00;
  logic [31:0] r_data = '0;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_r = 0;
  int ar_hi = 0, stab_err = 0, ord_err = 0;
  logic [31:0] rec_awaddr = '0, rec_wdata = '0, rec_araddr = '0;
  logic [3:0]  rec_wstrb = '0;
  logic [2:0]  rec_awprot = '0, rec_arprot = '0;

  // AXI-Lite slave: READY after a programmed number of VALID cycles, response after a delay.
  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_got, w_got, ar_got;
    logic p_aw, p_w, p_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    axi.AWREADY = 0; axi.WREADY = 0; axi.ARREADY = 0;
    axi.BVALID = 0; axi.BRESP = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
    aw_got = 0; w_got = 0; ar_got = 0; p_aw = 0; p_w = 0; p_ar = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        axi.AWREADY = 0; axi.WREADY = 0; axi.ARREADY = 0; axi.BVALID = 0; axi.RVALID = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        aw_got = 0; w_got = 0; ar_got = 0; p_aw = 0; p_w = 0; p_ar = 0;
        continue;
      end
      if (aw_fire) begin aw_got = 1; n_aw++; end
      if (w_fire)  begin w_got = 1;  n_w++;  end
      if (ar_fire) begin ar_got = 1; n_ar++; end
      if (b_fire)  begin axi.BVALID = 0; n_b++; end
      if (r_fire)  begin axi.RVALID = 0; n_r++; end
      if (p_aw && (!axi.AWVALID || axi.AWADDR !== p_awaddr)) stab_err++;
      if (p_w  && (!axi.WVALID  || axi.WDATA  !== p_wdata))  stab_err++;
      if (p_ar && (!axi.ARVALID || axi.ARADDR !== p_araddr)) stab_err++;
      if (axi.AWVALID) begin axi.AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
      else begin axi.AWREADY = 0; aw_cnt = 0; end
      if (axi.WVALID) begin axi.WREADY = (w_cnt >= w_dly); w_cnt++; end
      else begin axi.WREADY = 0; w_cnt = 0; end
      if (axi.ARVALID) begin axi.ARREADY = (ar_cnt >= ar_dly); ar_cnt++; ar_hi++; end
      else begin axi.ARREADY = 0; ar_cnt = 0; end
      aw_fire = axi.AWVALID && axi.AWREADY;
      w_fire  = axi.WVALID && axi.WREADY;
      ar_fire = axi.ARVALID && axi.ARREADY;
      if (aw_fire) begin rec_awaddr = axi.AWADDR; rec_awprot = axi.AWPROT; end
      if (w_fire)  begin rec_wdata = axi.WDATA; rec_wstrb = axi.WSTRB; end
      if (ar_fire) begin rec_araddr = axi.ARADDR; rec_arprot = axi.ARPROT; end
      p_aw = axi.AWVALID && !axi.AWREADY; p_awaddr = axi.AWADDR;
      p_w  = axi.WVALID && !axi.WREADY;   p_wdata  = axi.WDATA;
      p_ar = axi.ARVALID && !axi.ARREADY; p_araddr = axi.ARADDR;
      if (aw_got && w_got && !axi.BVALID) begin
        if (b_cnt >= b_dly) begin
          axi.BVALID = 1; axi.BRESP = b_resp; aw_got = 0; w_got = 0; b_cnt = 0;
        end else b_cnt++;
      end
      if (ar_got && !axi.RVALID) begin
        if (r_cnt >= r_dly) begin
          axi.RVALID = 1; axi.RDATA = r_data; axi.RRESP = r_resp; ar_got = 0; r_cnt = 0;
        end else r_cnt++;
      end
      b_fire = axi.BVALID && axi.BREADY;
      r_fire = axi.RVALID && axi.RREADY;
      if (axi.BREADY && (axi.AWVALID || axi.WVALID)) ord_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Core-side request: hold mem_valid until mem_ready (bounded), then release.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins, output int lat, output logic [31:0] rd,
                        output logic rdy_after, output logic [31:0] rd_after);
    @(negedge clk);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    lat = -1; rd = 'x;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (mem_ready) begin lat = n; rd = mem_rdata; break; end
    end
    mem_valid = 0;
    @(negedge clk);
    rdy_after = mem_ready; rd_after = mem_rdata;
  endtask

  task automatic hold_miss(input logic [31:0] a, input int cycles,
                           output int rdy_cnt, output int vld_cnt);
    @(negedge clk);
    mem_valid = 1; mem_addr = a; mem_wstrb = 4'b0000; mem_instr = 0;
    rdy_cnt = 0; vld_cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (mem_ready) rdy_cnt++;
      if (axi.AWVALID || axi.WVALID || axi.ARVALID) vld_cnt++;
    end
    mem_valid = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1; mem_valid = 0;
    @(negedge clk); @(negedge clk); reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    repeat (3) @(negedge clk);
    outs = {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY, mem_ready, bus_error};
    n_checks++; if (outs !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", outs); end
    n_checks++; if (mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", mem_rdata); end
    n_checks++; if (axi.AWADDR !== 32'd0 || axi.ARADDR !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h/%h expected 0", axi.AWADDR, axi.ARADDR); end
    n_checks++; if (axi.WDATA !== 32'd0 || axi.WSTRB !== 4'd0) begin n_fail++; $display("FAIL reset_wdata: got %h/%h expected 0", axi.WDATA, axi.WSTRB); end
    reset = 0;
  endtask

  task automatic test_write_basic();
    int lat; logic [31:0] rd, rda; logic ra;
    aw_dly = 0; w_dly = 0; b_dly = 0; b_resp = 0;
    do_req(32'h4000_0010, 32'hCAFE_F00D, 4'b0011, 0, lat, rd, ra, rda);
    n_checks++; if (rec_awaddr !== 32'h10) begin n_fail++; $display("FAIL wr_awaddr: got %h expected 10", rec_awaddr); end
    n_checks++; if (rec_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wr_wdata: got %h expected cafef00d", rec_wdata); end
    n_checks++; if (rec_wstrb !== 4'b0011) begin n_fail++; $display("FAIL wr_wstrb: got %b expected 0011", rec_wstrb); end
    n_checks++; if (rec_awprot !== 3'b000) begin n_fail++; $display("FAIL wr_awprot: got %b expected 000", rec_awprot); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL wr_rdata: got %h expected 0", rd); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_width: got %b expected 0", ra); end
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL wr_bus_error: got %b expected 0", bus_error); end
  endtask

  task automatic test_read_delay();
    int lat; logic [31:0] rd, rda; logic ra;
    ar_dly = 4; r_dly = 0; r_resp = 0; r_data = 32'h1234_5678; ar_hi = 0;
    do_req(32'h4000_0024, 32'h0, 4'b0000, 1, lat, rd, ra, rda);
    n_checks++; if (rec_araddr !== 32'h24) begin n_fail++; $display("FAIL rd_araddr: got %h expected 24", rec_araddr); end
    n_checks++; if (rec_arprot !== 3'b100) begin n_fail++; $display("FAIL rd_arprot: got %b expected 100", rec_arprot); end
    n_checks++; if (ar_hi !== 5) begin n_fail++; $display("FAIL rd_arvalid_cycles: got %0d expected 5", ar_hi); end
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data: got %h expected 12345678", rd); end
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL rd_latency: got %0d expected 7", lat); end
    n_checks++; if (ra !== 1'b0 || rda !== 32'd0) begin n_fail++; $display("FAIL rd_pulse_after: got %b/%h expected 0/0", ra, rda); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL rd_stability: got %0d expected 0", stab_err); end
    ar_dly = 0;
  endtask

  task automatic test_write_order();
    int lat, aw0, w0, b0; logic [31:0] rd, rda; logic ra;
    aw_dly = 3; w_dly = 0; b_dly = 0; aw0 = n_aw; w0 = n_w; b0 = n_b;
    do_req(32'h4000_0100, 32'h5555_AAAA, 4'b1111, 0, lat, rd, ra, rda);
    n_checks++; if (ord_err !== 0) begin n_fail++; $display("FAIL wo_bready_order: got %0d expected 0", ord_err); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL wo_latency: got %0d expected 6", lat); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL wo_single_pulse: got %b expected 0", ra); end
    n_checks++; if (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_b - b0 !== 1) begin n_fail++; $display("FAIL wo_beats: got %0d/%0d/%0d expected 1/1/1", n_aw - aw0, n_w - w0, n_b - b0); end
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL wo_stability: got %0d expected 0", stab_err); end
    aw_dly = 0;
  endtask

  task automatic test_out_of_window();
    int rc, vc;
    hold_miss(32'h0000_0100, 50, rc, vc);
    n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL oow_ready: got %0d expected 0", rc); end
    n_checks++; if (vc !== 0) begin n_fail++; $display("FAIL oow_valid: got %0d expected 0", vc); end
  endtask

  task automatic test_boundary();
    int lat, rc, vc; logic [31:0] rd, rda; logic ra;
    r_data = 32'hA5A5_0001;
    do_req(BASE, 32'h0, 4'b0000, 0, lat, rd, ra, rda);
    n_checks++; if (rec_araddr !== 32'h0 || rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL bnd_low: got %h/%h expected 0/a5a50001", rec_araddr, rd); end
    do_req(BASE + WIN - 1, 32'h0BAD_F00D, 4'b1000, 0, lat, rd, ra, rda);
    n_checks++; if (rec_awaddr !== 32'hFFFC || lat !== 3) begin n_fail++; $display("FAIL bnd_high: got %h/%0d expected fffc/3", rec_awaddr, lat); end
    hold_miss(BASE + WIN, 10, rc, vc);
    n_checks++; if (rc !== 0 || vc !== 0) begin n_fail++; $display("FAIL bnd_above: got %0d/%0d expected 0/0", rc, vc); end
    hold_miss(BASE - 1, 10, rc, vc);
    n_checks++; if (rc !== 0 || vc !== 0) begin n_fail++; $display("FAIL bnd_below: got %0d/%0d expected 0/0", rc, vc); end
  endtask

  task automatic test_random();
    int lat, m, exp_lat, aw0, ar0; logic [31:0] a, d, rd, rda, exp_a; logic [3:0] s; logic ins, ra;
    for (int i = 0; i < 30; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      a = BASE + $urandom_range(0, 32'hFFFF); d = $urandom; r_data = $urandom; ins = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      exp_a = (a - BASE) & 32'hFFFF_FFFC;
      aw0 = n_aw; ar0 = n_ar;
      do_req(a, d, s, ins, lat, rd, ra, rda);
      if (s != 0) begin
        m = (aw_dly > w_dly) ? aw_dly : w_dly;
        exp_lat = 3 + m + b_dly;
        n_checks++; if (rec_awaddr !== exp_a || rec_wdata !== d || rec_wstrb !== s) begin n_fail++; $display("FAIL rnd_wr_beat[%0d]: got %h/%h/%h expected %h/%h/%h", i, rec_awaddr, rec_wdata, rec_wstrb, exp_a, d, s); end
        n_checks++; if (rd !== 32'd0 || n_aw - aw0 !== 1 || n_ar !== ar0) begin n_fail++; $display("FAIL rnd_wr_resp[%0d]: got rdata %h aw %0d ar %0d expected 0/1/0", i, rd, n_aw - aw0, n_ar - ar0); end
      end else begin
        exp_lat = 3 + ar_dly + r_dly;
        n_checks++; if (rec_araddr !== exp_a || rec_arprot !== {ins, 2'b00}) begin n_fail++; $display("FAIL rnd_rd_beat[%0d]: got %h/%b expected %h/%b", i, rec_araddr, rec_arprot, exp_a, {ins, 2'b00}); end
        n_checks++; if (rd !== r_data || n_ar - ar0 !== 1 || n_aw !== aw0) begin n_fail++; $display("FAIL rnd_rd_resp[%0d]: got %h ar %0d aw %0d expected %h/1/0", i, rd, n_ar - ar0, n_aw - aw0, r_data); end
      end
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      n_checks++; if (ra !== 1'b0 || rda !== 32'd0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL rnd_after[%0d]: got %b/%h/%b expected 0/0/0", i, ra, rda, bus_error); end
    end
    n_checks++; if (stab_err !== 0 || ord_err !== 0) begin n_fail++; $display("FAIL rnd_protocol: got %0d/%0d expected 0/0", stab_err, ord_err); end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, aw0;
    aw0 = n_aw;
    @(negedge clk);
    mem_valid = 1; mem_addr = BASE + 32'h40; mem_wdata = 32'h1111_2222; mem_wstrb = 4'hF; mem_instr = 0;
    lat1 = -1; lat2 = -1;
    for (int n = 1; n <= 50; n++) begin @(negedge clk); if (mem_ready) begin lat1 = n; break; end end
    mem_addr = BASE + 32'h44; mem_wdata = 32'h3333_4444;
    for (int n = 1; n <= 50; n++) begin @(negedge clk); if (mem_ready) begin lat2 = n; break; end end
    mem_valid = 0;
    @(negedge clk);
    n_checks++; if (lat1 !== 3) begin n_fail++; $display("FAIL b2b_first: got %0d expected 3", lat1); end
    n_checks++; if (lat2 !== 4) begin n_fail++; $display("FAIL b2b_second: got %0d expected 4", lat2); end
    n_checks++; if (n_aw - aw0 !== 2 || rec_awaddr !== 32'h44 || rec_wdata !== 32'h3333_4444) begin n_fail++; $display("FAIL b2b_beats: got %0d/%h/%h expected 2/44/33334444", n_aw - aw0, rec_awaddr, rec_wdata); end
  endtask

  task automatic test_error();
    int lat; logic [31:0] rd, rda; logic ra;
    r_resp = 2'b10; r_data = 32'hFEED_0042;
    do_req(BASE + 32'h8, 32'h0, 4'b0000, 0, lat, rd, ra, rda);
    n_checks++; if (rd !== 32'hFEED_0042 || lat !== 3) begin n_fail++; $display("FAIL err_rd_complete: got %h/%0d expected feed0042/3", rd, lat); end
    n_checks++; if (bus_error !== 1'b1) begin n_fail++; $display("FAIL err_rd_flag: got %b expected 1", bus_error); end
    r_resp = 2'b00;
    do_req(BASE + 32'hC, 32'h77, 4'b0001, 0, lat, rd, ra, rda);
    n_checks++; if (bus_error !== 1'b1 || lat !== 3) begin n_fail++; $display("FAIL err_sticky: got %b/%0d expected 1/3", bus_error, lat); end
    pulse_reset();
    n_checks++; if (bus_error !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", bus_error); end
    b_resp = 2'b11;
    do_req(BASE + 32'h10, 32'h99, 4'b0100, 0, lat, rd, ra, rda);
    n_checks++; if (bus_error !== 1'b1 || lat !== 3) begin n_fail++; $display("FAIL err_wr_flag: got %b/%0d expected 1/3", bus_error, lat); end
    b_resp = 2'b00;
  endtask

  task automatic test_reset_mid();
    int seen, rc;
    pulse_reset();
    b_dly = 10; seen = 0; rc = 0;
    @(negedge clk);
    mem_valid = 1; mem_addr = BASE + 32'h20; mem_wdata = 32'hABCD; mem_wstrb = 4'hF;
    for (int n = 0; n < 20; n++) begin @(negedge clk); if (axi.BREADY) begin seen = 1; break; end end
    reset = 1;
    @(negedge clk);
    n_checks++; if (seen !== 1 || axi.BREADY !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bready: got seen %0d bready %b expected 1/0", seen, axi.BREADY); end
    n_checks++; if (mem_ready !== 1'b0 || bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %b/%b expected 0/0", mem_ready, bus_error); end
    @(negedge clk); reset = 0; mem_valid = 0;
    for (int n = 0; n < 15; n++) begin @(negedge clk); if (mem_ready) rc++; end
    n_checks++; if (rc !== 0) begin n_fail++; $display("FAIL rst_mid_no_pulse: got %0d expected 0", rc); end
    b_dly = 0;
  endtask

`ifdef FISMOS_AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int lat; logic [31:0] rd, rda; logic ra;
    ar_dly = 100000; ar_hi = 0;
    do_req(BASE + 32'h4, 32'h0, 4'b0000, 0, lat, rd, ra, rda);
    n_checks++; if (ar_hi !== 16) begin n_fail++; $display("FAIL tmo_arvalid_cycles: got %0d expected 16", ar_hi); end
    n_checks++; if (lat !== 17 || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL tmo_response: got %0d/%h expected 17/deadbeef", lat, rd); end
    n_checks++; if (bus_error !== 1'b1 || ra !== 1'b0) begin n_fail++; $display("FAIL tmo_flag: got %b/%b expected 1/0", bus_error, ra); end
    ar_dly = 0;
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_read_delay();
    test_write_order();
    test_out_of_window();
    test_boundary();
    test_random();
    test_back_to_back();
    test_error();
    test_reset_mid();
`ifdef FISMOS_AXIL_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fismos_axil_master.md
Name: fismos_axil_master

Overview:
- Bridges the PicoRV32 native memory port to an AXI4-Lite master, the initiator counterpart of the shared-memory AXI slave.
- Lets the softcore issue single-beat reads and writes to external AXI-Lite peripherals mapped into a fixed address window.
- Sits beside cpu_memory and io_memory on the core's memory bus. Its mem_ready/mem_rdata join the existing ready/data merge.
- Stays silent for addresses outside its window.

Parameters:
AXI_ADDR_WIDTH, 32, width of M_AXI_AWADDR/M_AXI_ARADDR
AXI_DATA_WIDTH, 32, AXI data width; only 32 supported
BASE_ADDR, 32'h4000_0000, first core address of the window
WINDOW_BYTES, 32'h0001_0000, window size in bytes; power of two
TIMEOUT_CYCLES, 1024, handshake timeout; used only with the optional feature

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
mem_valid  in  1  core request valid
mem_instr  in  1  request is an instruction fetch
mem_addr  in  32  core byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte strobes; 0 means read
mem_ready  out  1  one-cycle completion pulse, window hits only
mem_rdata  out  32  read data, valid while mem_ready=1
M_AXI_AWVALID/AWREADY  out/in  1  write address handshake
M_AXI_AWADDR  out  AXI_ADDR_WIDTH  write address
M_AXI_AWPROT  out  3  fixed 3'b000
M_AXI_WVALID/WREADY  out/in  1  write data handshake
M_AXI_WDATA  out  32  write data
M_AXI_WSTRB  out  4  write strobes
M_AXI_BVALID/BREADY  in/out  1  write response handshake
M_AXI_BRESP  in  2  write response
M_AXI_ARVALID/ARREADY  out/in  1  read address handshake
M_AXI_ARADDR  out  AXI_ADDR_WIDTH  read address
M_AXI_ARPROT  out  3  {mem_instr,2'b00}
M_AXI_RVALID/RREADY  in/out  1  read data handshake
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
bus_error  out  1  sticky error flag

Behaviour:
- Reset:
  - State IDLE.
  - All VALID/READY outputs 0, mem_ready 0, mem_rdata 0, bus_error 0.
  - AXI address/data/strb registers 0.
- Window hit: BASE_ADDR <= mem_addr < BASE_ADDR+WINDOW_BYTES.
  - Outside the window: mem_ready stays 0 and no AXI activity occurs.
  - Required because the top merges ready signals by XOR.
- Address translation: AXI address = (mem_addr - BASE_ADDR), truncated to AXI_ADDR_WIDTH, with bits [1:0] forced 0.
- Request acceptance:
  - Accepted in IDLE when mem_valid & hit & !mem_ready.
  - Address, wdata, wstrb and instr are registered at acceptance; the core may not change them but the block never re-samples them.
- States: IDLE, WRITE, WRESP, READ, RDATA, DONE.
- IDLE:
  - A write request (wstrb != 0) goes to WRITE; AWVALID and WVALID both rise on the next cycle.
  - A read request goes to READ; ARVALID rises on the next cycle.
- WRITE:
  - AWVALID and WVALID each drop independently on their own handshake. Either order, or simultaneous, is legal.
  - When both channels are done, go to WRESP with BREADY=1.
- WRESP: on BVALID, BREADY drops; go to DONE.
- READ: on ARREADY, ARVALID drops; go to RDATA with RREADY=1.
- RDATA: on RVALID, RDATA is captured into mem_rdata, RREADY drops; go to DONE.
- DONE:
  - mem_ready=1 for exactly one cycle, then IDLE.
  - mem_rdata=0 for writes.
  - mem_rdata returns to 0 in the cycle after DONE.
- Latency with a zero-wait slave:
  - Write: acceptance edge k → AW/W at k+1 → B at k+2 → mem_ready at k+3.
  - Read: acceptance edge k → AR at k+1 → R at k+2 → mem_ready at k+3.
- VALID stability: once a VALID is raised it holds, with address/data stable, until its handshake. No dependence on READY before asserting VALID.
- Error responses: BRESP or RRESP != OKAY sets bus_error (sticky until reset). The transaction still completes normally, with RDATA passed through.
- Back-to-back requests: a new request is not accepted in the DONE cycle. Earliest next acceptance is the first IDLE cycle.
- Reset mid-transaction: returns to IDLE immediately. All VALID/READY outputs drop in the same edge, with no response pulse.

Optional Feature:
- Macro: FISMOS_AXIL_MASTER_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WRITE/WRESP/READ/RDATA and increments each cycle spent in them.
  - On reaching TIMEOUT_CYCLES-1 without completion:
    - All VALID/READY outputs drop.
    - bus_error is set.
    - mem_rdata is 32'hDEAD_BEEF.
    - The FSM goes to DONE, giving a single mem_ready pulse.
  - The counter is sized $clog2(TIMEOUT_CYCLES)+1.
- When undefined: no counter; the block waits indefinitely for the slave.

Test Plan:
- Write 0x4000_0010 data 0xCAFE_F00D wstrb 4'b0011, always-ready slave → AWADDR=0x10, WDATA=0xCAFEF00D, WSTRB=0011; mem_ready 3 cycles after acceptance; bus_error=0.
- Read 0x4000_0024, slave ARREADY delayed 4 cycles, RDATA=0x1234_5678 → ARVALID held stable 5 cycles; mem_rdata=0x12345678 with a one-cycle mem_ready.
- Write with WREADY arriving 3 cycles before AWREADY → each VALID drops on its own handshake; BREADY rises only after both; single mem_ready.
- Read 0x0000_0100 (outside window) → no AXI VALID asserted, mem_ready stays 0 for 50 cycles.
- Read with RRESP=2'b10 (SLVERR) → transaction completes, bus_error=1 and stays 1 across a following OKAY write until reset.
- With FISMOS_AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts ARREADY → ARVALID drops after 16 cycles; mem_ready pulse with mem_rdata=0xDEADBEEF; bus_error=1.
- Reset asserted during WRESP → BREADY=0 next cycle, no mem_ready.
